pipe_stage_skid: RTL and testbench

//  Next-generation inter-stage pipeline register (ID/EX, EX/MEM, MEM/WB) for the pipelined CPU.

---
 rtl/pipe_stage_skid.sv | 119 +++++++++++
 tb/tb_pipe_stage_skid.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - inter-stage pipeline register with 2-entry skid buffer and valid/ready handshake
// Optional back-pressure counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_skid #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic                in_fire;
  logic                out_fire;

  // Handshake outputs depend only on state registers (plus reset), never on out_ready.
  assign out_valid = (state_q != S_EMPTY);
  assign in_ready  = (state_q != S_TWO) & ~reset;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign out_data  = main_data_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d     = S_ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (in_fire) begin
            state_d     = S_TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (out_fire) begin
            state_d     = S_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating; flush deliberately leaves the count alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 9;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_skid #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] d);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = d[CTRL_W-1:0];
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 64'hDEAD;
    in_ctrl = 9'h1FF; out_ready = 1'b1;

    // 1 reset held two cycles with in_valid asserted
    tick();
    chk("rst_in_ready_0", in_ready, 0);
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready_1", in_ready, 0);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    tick();
    chk("post_rst_out_valid", out_valid, 0);

    // 2 streaming with out_ready high
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      send(64'(k));
      #1;
      chk("stream_in_ready", in_ready, 1);
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, 64'(k));
      chk("stream_ctrl", out_ctrl, 64'(k));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_valid", out_valid, 0);
    chk("stream_drain_ctrl", out_ctrl, 0);
    chk("stream_data_held", out_data, 64'd8);

    // 3 stall: A held, B into skid, C blocked
    out_ready = 1'b0;
    send(64'hA);
    tick();
    chk("stall_A_out", out_data, 64'hA);
    chk("stall_A_rdy", in_ready, 1);
    send(64'hB);
    tick();
    chk("stall_B_rdy", in_ready, 0);
    chk("stall_B_out", out_data, 64'hA);
    send(64'hC);
    tick();
    chk("stall_C_blk_out", out_data, 64'hA);
    chk("stall_C_blk_ctrl", out_ctrl, 64'hA);
    chk("stall_C_blk_rdy", in_ready, 0);
    out_ready = 1'b1;
    tick();
    chk("rel_B_out", out_data, 64'hB);
    chk("rel_B_rdy", in_ready, 1);
    tick();
    chk("rel_C_out", out_data, 64'hC);
    chk("rel_C_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();
    chk("rel_empty", out_valid, 0);

    // 4 flush in TWO with incoming beat, then flush in ONE with accepted beat
    out_ready = 1'b0;
    send(64'h11); tick();
    send(64'h22); tick();
    chk("flush_pre_rdy", in_ready, 0);
    flush = 1'b1; send(64'h55);
    tick();
    chk("flush2_valid", out_valid, 0);
    chk("flush2_ctrl", out_ctrl, 0);
    chk("flush2_rdy", in_ready, 1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("flush2_after_valid", out_valid, 0);
    chk("flush2_no55", out_data == 64'h55, 0);
    send(64'h33); tick();
    chk("flush1_pre", out_data, 64'h33);
    out_ready = 1'b0; flush = 1'b1; send(64'h66);
    tick();
    chk("flush1_valid", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("flush1_still_empty", out_valid, 0);

    // 5 bubble ctrl never leaks
    in_valid = 1'b0; in_ctrl = 9'h1FF; in_data = 64'h77;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bubble_valid", out_valid, 0);
      chk("bubble_ctrl", out_ctrl, 0);
    end

    // 6 stall counter
    reset = 1'b1; tick(); reset = 1'b0;
`ifdef PIPE_STALL_CNT_EN
    chk("cnt_reset", stall_cnt, 0);
    out_ready = 1'b0;
    send(64'h9); tick(); in_valid = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk("cnt_sat", stall_cnt, 15);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("cnt_flush_keep", stall_cnt, 15);
    tick();
    chk("cnt_after_flush", stall_cnt, 15);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("cnt_cleared", stall_cnt, 0);
`else
    out_ready = 1'b0;
    send(64'h9); tick(); in_valid = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk("cnt_tied_zero", stall_cnt, 0);
    chk("cnt_stall_hold", out_data, 64'h9);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
